// File: rtl/door_lock_param_pkg.sv
// Shared state encoding and width helpers for the parametrised keypad door lock.
// Optional reprogramming support is enabled with DOOR_LOCK_PROG_EN in door_lock_param.
package door_lock_pkg;

  typedef enum logic [2:0] {
    ENTRY    = 3'd0,
    UNLOCKED = 3'd1,
    ERROR    = 3'd2,
    LOCKOUT  = 3'd3,
    PROGRAM  = 3'd4
  } lock_state_e;

  // Counter widths never collapse to zero bits, even for a single-value range.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/door_lock_param_timer.sv
// Loadable saturating down-counter shared by the unlock window and the lockout period.
// zero_o flags the enabled cycle whose decrement lands on zero (count <= 1).
module lock_timer #(
  parameter int unsigned W = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  // Looking one step ahead makes a load of N give exactly N cycles in the state.
  assign zero_o = (count_q <= W'(1));

endmodule

// File: rtl/door_lock_param.sv
// Keypad door lock: on-the-fly code compare, timed unlock window, fail counting and lockout.
// Define DOOR_LOCK_PROG_EN to allow reprogramming the code from the UNLOCKED state.
module door_lock_param
  import door_lock_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned DIGIT_W        = 4,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'h4132,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned UNLOCK_CYCLES  = 500,
  parameter int unsigned LOCKOUT_CYCLES = 1000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enter,
  input  logic [DIGIT_W-1:0]               digit,
  input  logic                             clear,
  input  logic                             prog,
  output logic                             unlock,
  output logic                             error,
  output logic                             locked_out,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count
);

  localparam int unsigned CODE_W = NUM_DIGITS * DIGIT_W;
  localparam int unsigned IDX_W  = clog2_min1(NUM_DIGITS);
  localparam int unsigned FC_W   = $clog2(MAX_FAILS + 1);
  localparam int unsigned TMR_W  = clog2_min1(max_u(UNLOCK_CYCLES, LOCKOUT_CYCLES) + 1);
  localparam int unsigned LAST_I = NUM_DIGITS - 1;

  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(LAST_I);
  localparam logic [FC_W-1:0]  FAIL_MAX     = FC_W'(MAX_FAILS);
  localparam logic [TMR_W-1:0] UNLOCK_LOAD  = TMR_W'(UNLOCK_CYCLES);
  localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES);

  lock_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             mis_q, mis_d;
  logic [FC_W-1:0]  fail_q, fail_d;
  logic             enter_q;
  logic             unlock_q, error_q, locked_q;

  logic             accept;
  logic             digit_bad;
  logic [DIGIT_W-1:0] exp_digit;
  logic [31:0]      sh_amt;
  logic [FC_W-1:0]  fail_inc;
  logic [CODE_W-1:0] code_w;

  logic             tmr_load, tmr_en, tmr_zero;
  logic [TMR_W-1:0] tmr_val;

`ifdef DOOR_LOCK_PROG_EN
  logic [CODE_W-1:0] code_q, code_d, shadow_q, shadow_d;
  assign code_w = code_q;
`else
  logic unused_prog;
  assign unused_prog = prog;
  assign code_w      = DEFAULT_CODE;
`endif

  // enter_q resets high so a strobe held through reset release is not taken as a digit.
  assign accept    = enter && !enter_q;
  assign sh_amt    = DIGIT_W * (LAST_I - 32'(idx_q));
  assign exp_digit = DIGIT_W'(code_w >> sh_amt);
  assign digit_bad = (digit != exp_digit);
  assign fail_inc  = (fail_q == FAIL_MAX) ? fail_q : fail_q + FC_W'(1);

  lock_timer #(.W(TMR_W)) u_timer (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mis_d    = mis_q;
    fail_d   = fail_q;
    tmr_load = 1'b0;
    tmr_val  = UNLOCK_LOAD;
    tmr_en   = 1'b0;
`ifdef DOOR_LOCK_PROG_EN
    code_d   = code_q;
    shadow_d = shadow_q;
`endif
    case (state_q)
      // An accept in ERROR is digit 0 of a fresh attempt, so both states share this path.
      ENTRY, ERROR: begin
        if (clear) begin
          state_d = ENTRY;
          idx_d   = '0;
          mis_d   = 1'b0;
        end else if (accept) begin
          state_d = ENTRY;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            mis_d = 1'b0;
            if (!(mis_q || digit_bad)) begin
              state_d  = UNLOCKED;
              tmr_load = 1'b1;
              tmr_val  = UNLOCK_LOAD;
              fail_d   = '0;
            end else begin
              fail_d = fail_inc;
              if (fail_inc == FAIL_MAX) begin
                state_d  = LOCKOUT;
                tmr_load = 1'b1;
                tmr_val  = LOCKOUT_LOAD;
              end else begin
                state_d = ERROR;
              end
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
            mis_d = mis_q | digit_bad;
          end
        end
      end
      UNLOCKED: begin
        tmr_en = 1'b1;
        if (clear || tmr_zero) begin
          state_d = ENTRY;
`ifdef DOOR_LOCK_PROG_EN
        end else if (prog) begin
          state_d = PROGRAM;
          idx_d   = '0;
`endif
        end
      end
      LOCKOUT: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          state_d = ENTRY;
          fail_d  = '0;
        end
      end
`ifdef DOOR_LOCK_PROG_EN
      PROGRAM: begin
        if (clear) begin
          state_d = ENTRY;
          idx_d   = '0;
        end else if (accept) begin
          shadow_d = (shadow_q << DIGIT_W) | CODE_W'(digit);
          if (idx_q == LAST_IDX) begin
            code_d  = shadow_d;
            state_d = ENTRY;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`endif
      default: begin
        state_d = ENTRY;
        idx_d   = '0;
        mis_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ENTRY;
      idx_q    <= '0;
      mis_q    <= 1'b0;
      fail_q   <= '0;
      enter_q  <= 1'b1;
      unlock_q <= 1'b0;
      error_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mis_q    <= mis_d;
      fail_q   <= fail_d;
      enter_q  <= enter;
      unlock_q <= (state_d == UNLOCKED) || (state_d == PROGRAM);
      error_q  <= (state_d == ERROR) || (state_d == LOCKOUT);
      locked_q <= (state_d == LOCKOUT);
    end
  end

`ifdef DOOR_LOCK_PROG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_q   <= DEFAULT_CODE;
      shadow_q <= '0;
    end else begin
      code_q   <= code_d;
      shadow_q <= shadow_d;
    end
  end
`endif

  assign unlock     = unlock_q;
  assign error      = error_q;
  assign locked_out = locked_q;
  assign fail_count = fail_q;

endmodule
